median_filter_nch: RTL and testbench
====================================

MEDIAN_FILTER_NCH -- requirements
Module: median_filter_nch

Parameters
REQ-001 CH, default 3: number of colour channels, 1..4.
REQ-002 DW, default 8: bits per channel sample, 4..12.
REQ-003 IMG_W, default 640: active pixels per line, 8..2048; line-buffer depth.

Interface
REQ-004 sclk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous to sclk, active-high.
REQ-006 rx_data  in  CH*DW  packed input pixel; channel k at bits [k*DW +: DW], channel 0 = R.
REQ-007 pi_flag  in  1  input pixel valid, one pixel per cycle when high.
REQ-008 i_vs  in  1  frame sync; rising edge marks frame start.
REQ-009 mode  in  2  00 bypass, 01 3x3 median, 10 3x3 min (erode), 11 3x3 max (dilate).
REQ-010 tx_data  out  CH*DW  packed filtered pixel, same packing as rx_data.
REQ-011 po_flag  out  1  output pixel valid.
REQ-012 o_vs  out  1  i_vs delayed to align with tx_data/po_flag.

Function
REQ-013 Latency: fixed LAT = 4 cycles in every mode; pi_flag at cycle t gives po_flag at t+4; tx_data valid in the same cycle.
REQ-014 o_vs shall equal i_vs delayed exactly LAT cycles.
REQ-015 Output pixel count per frame equals input pixel count; gaps in pi_flag propagate unchanged, shifted by LAT.
REQ-016 Column counter col: 0..IMG_W-1, increments on each pi_flag, wraps to 0; each wrap increments row counter row, saturating at 2047.
REQ-017 Rising edge of i_vs (i_vs high, previous sample low) clears col and row and samples mode into mode_r; a pi_flag in that same cycle counts as col 0, row 0.
REQ-018 mode changes between frame starts are ignored; mode_r holds for the whole frame.
REQ-019 Per channel: two line buffers of IMG_W x DW; on pi_flag, read the previous value at address col before writing the new one (read-before-write).
REQ-020 Per channel: 3x3 window shift register loaded only on pi_flag; the newest column is {line1[col], line0[col], rx_data}.
REQ-021 The window centre corresponds to image position (row-1, col-1); filtered output is spatially shifted by one row and one column.
REQ-022 Border: when row<2 or col<2 at input time, output equals that input sample (bypass path), regardless of mode_r.
REQ-023 Median pipeline, each stage registered:
  - stage 1: sort each window column into min/mid/max;
  - stage 2: max of the three mins, median of the three mids, min of the three maxes;
  - stage 3: median of those three values.
REQ-024 Min/max modes: min (or max) over all 9 samples, pipelined to the same LAT.
REQ-025 Bypass (mode_r=00): tx_data = rx_data delayed LAT cycles.
REQ-026 All comparisons unsigned DW-bit; no arithmetic widening; ties resolve to an equal value, so the result is always a member of the window.
REQ-027 All channels share counters, flags and mode; channels are independent only in data.
REQ-028 pi_flag high continuously across a line wrap: no bubble, no dropped pixel.

Reset
REQ-029 While rst is high:
  - tx_data, po_flag, o_vs, pipeline valid bits, col and row clear to 0;
  - the i_vs edge-detector history clears to 0;
  - mode_r resets to 01.
REQ-030 Line-buffer and window contents are not reset; border bypass (REQ-022) masks stale data.
REQ-031 rst asserted mid-frame discards in-flight pixels: no po_flag for them after rst falls; the next frame needs a new i_vs rising edge for counter alignment.

Verification (IMG_W=8, CH=3, DW=8)
REQ-032 Flat frame, all samples 0x40, mode 01, 8x8 continuous pi_flag -> 64 po_flag pulses, all tx_data = 0x404040, first po_flag 4 cycles after first pi_flag.
REQ-033 Impulse: 0xFF at one interior pixel (row 3, col 3), rest 0x10, mode 01 -> no output equals 0xFF; mode 11 -> nine outputs equal 0xFF (input positions rows 3-5, cols 3-5).
REQ-034 Border check: row-0 samples 0x00..0x07, mode 10 -> first 8 outputs equal 0x00..0x07 exactly (bypass).
REQ-035 mode switched 01->00 mid-frame -> filtering continues until the next i_vs rise; the next frame is a pure LAT-delayed copy of the input.
REQ-036 Gapped pi_flag (1 on / 2 off) -> po_flag pattern identical to input shifted 4 cycles, data matching the continuous run.
REQ-037 rst pulsed for 1 cycle mid-line -> all outputs 0 next cycle, no stale po_flag; after a new i_vs edge, the frame output matches the golden model.

Source files
------------

// File: rtl/median_filter_nch_if.sv
// Pixel stream bundle for median_filter_nch: input pixel/flag/sync/mode and the
// filtered output pixel/flag/sync, with source (master) and filter (slave) views.
interface median_filter_nch_if #(
  parameter int CH = 3,
  parameter int DW = 8
);
  logic [CH*DW-1:0] rx_data;
  logic             pi_flag;
  logic             i_vs;
  logic [1:0]       mode;
  logic [CH*DW-1:0] tx_data;
  logic             po_flag;
  logic             o_vs;

  modport master (
    output rx_data, pi_flag, i_vs, mode,
    input  tx_data, po_flag, o_vs
  );

  modport slave (
    input  rx_data, pi_flag, i_vs, mode,
    output tx_data, po_flag, o_vs
  );
endinterface

// File: rtl/median_filter_nch.sv
// Multi-channel 3x3 median / erode / dilate filter with two line buffers per channel
// and a fixed 4-cycle latency; borders (row<2 or col<2) pass the input through.
module median_filter_nch #(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int IMG_W = 640
) (
  input  logic             sclk,
  input  logic             rst,
  median_filter_nch_if.slave bus
);
  localparam int W  = CH * DW;
  localparam int CW = $clog2(IMG_W);
  localparam logic [10:0] ROW_MAX = 11'd2047;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_MEDIAN = 2'b01,
    MODE_MIN    = 2'b10,
    MODE_MAX    = 2'b11
  } mode_e;

  function automatic logic [DW-1:0] mx2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] mn2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return mx2(mn2(a, b), mn2(mx2(a, b), c));
  endfunction

  // Frame position and mode, with a frame-start edge taking effect in its own cycle
  logic          vs_prev;
  logic          vs_rise;
  logic [CW-1:0] col;
  logic [CW-1:0] col_eff;
  logic [10:0]   row;
  logic [10:0]   row_eff;
  logic          line_end;
  logic          border;
  mode_e         mode_r;
  mode_e         mode_eff;

  assign vs_rise  = bus.i_vs & ~vs_prev;
  assign col_eff  = vs_rise ? '0 : col;
  assign row_eff  = vs_rise ? '0 : row;
  assign mode_eff = vs_rise ? mode_e'(bus.mode) : mode_r;
  assign line_end = (col_eff == CW'(IMG_W - 1));
  assign border   = (row_eff < 11'd2) || (col_eff < CW'(2));

  always_ff @(posedge sclk) begin
    if (rst) begin
      vs_prev <= 1'b0;
      col     <= '0;
      row     <= '0;
      mode_r  <= MODE_MEDIAN;
    end else begin
      vs_prev <= bus.i_vs;
      if (vs_rise) mode_r <= mode_e'(bus.mode);
      if (bus.pi_flag) begin
        col <= line_end ? '0 : col_eff + CW'(1);
        row <= (line_end && row_eff != ROW_MAX) ? row_eff + 11'd1 : row_eff;
      end else begin
        col <= col_eff;
        row <= row_eff;
      end
    end
  end

  // Control pipeline: valid and sync are reset, per-pixel select and bypass data are not
  logic [2:0]   v;
  logic [3:0]   vs_d;
  mode_e        sel [3];
  logic [W-1:0] byp [3];
  logic [W-1:0] res;
  logic [W-1:0] tx_q;
  logic         po_q;

  always_ff @(posedge sclk) begin
    if (rst) begin
      v    <= '0;
      vs_d <= '0;
    end else begin
      v    <= {v[1:0], bus.pi_flag};
      vs_d <= {vs_d[2:0], bus.i_vs};
    end
  end

  // NOTE: data-path registers carry no reset; the reset valid bits decide what is ever observed.
  always_ff @(posedge sclk) begin
    sel[0] <= border ? MODE_BYPASS : mode_eff;
    sel[1] <= sel[0];
    sel[2] <= sel[1];
    byp[0] <= bus.rx_data;
    byp[1] <= byp[0];
    byp[2] <= byp[1];
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0] line0 [IMG_W];
    logic [DW-1:0] line1 [IMG_W];
    logic [DW-1:0] win [3][3];
    logic [DW-1:0] lo [3];
    logic [DW-1:0] md [3];
    logic [DW-1:0] hi [3];
    logic [DW-1:0] s2_a, s2_b, s2_c, s2_mn, s2_mx;
    logic [DW-1:0] px;
    logic [DW-1:0] y;

    assign px = bus.rx_data[k*DW +: DW];

    // NOTE: line buffers and window are storage, not state: no reset, the border path masks stale contents.
    always_ff @(posedge sclk) begin
      if (bus.pi_flag) begin
        line0[col_eff] <= px;
        line1[col_eff] <= line0[col_eff];
        win[0]         <= win[1];
        win[1]         <= win[2];
        win[2]         <= '{line1[col_eff], line0[col_eff], px};
      end
    end

    always_ff @(posedge sclk) begin
      for (int i = 0; i < 3; i++) begin
        lo[i] <= mn2(mn2(win[i][0], win[i][1]), win[i][2]);
        md[i] <= med3(win[i][0], win[i][1], win[i][2]);
        hi[i] <= mx2(mx2(win[i][0], win[i][1]), win[i][2]);
      end
      s2_a  <= mx2(mx2(lo[0], lo[1]), lo[2]);
      s2_b  <= med3(md[0], md[1], md[2]);
      s2_c  <= mn2(mn2(hi[0], hi[1]), hi[2]);
      s2_mn <= mn2(mn2(lo[0], lo[1]), lo[2]);
      s2_mx <= mx2(mx2(hi[0], hi[1]), hi[2]);
    end

    // NOTE: default assignment first keeps this process free of inferred latches.
    always_comb begin
      y = byp[2][k*DW +: DW];
      case (sel[2])
        MODE_MEDIAN: y = med3(s2_a, s2_b, s2_c);
        MODE_MIN:    y = s2_mn;
        MODE_MAX:    y = s2_mx;
        default:     ;
      endcase
    end

    assign res[k*DW +: DW] = y;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      tx_q <= '0;
      po_q <= 1'b0;
    end else begin
      tx_q <= res;
      po_q <= v[2];
    end
  end

  assign bus.tx_data = tx_q;
  assign bus.po_flag = po_q;
  assign bus.o_vs    = vs_d[3];
endmodule

// File: tb/tb_median_filter_nch.sv
// Randomized self-checking bench for median_filter_nch (CH=3, DW=8, IMG_W=8) against an
// image-array reference that sorts each 3x3 neighbourhood.
module tb_median_filter_nch;
  localparam int CH    = 3;
  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int W     = CH * DW;
  localparam int NCYC  = 8192;

  logic sclk = 1'b0;
  logic rst;
  always #5 sclk = ~sclk;

  median_filter_nch_if #(.CH(CH), .DW(DW)) bus ();

  median_filter_nch #(.CH(CH), .DW(DW), .IMG_W(IMG_W)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit           exp_flag [NCYC];
  bit           exp_vs   [NCYC];
  bit           exp_zero [NCYC];
  logic [W-1:0] exp_data [NCYC];

  bit           m_vs_prev;
  int           m_col, m_row;
  logic [1:0]   m_mode;
  logic [W-1:0] img [16][IMG_W];

  logic [1:0]   mode_in;
  logic [W-1:0] frame_pix [64];
  int           ff_count, po_count;
  bit           capture;
  logic [W-1:0] cap_q [$];
  logic [W-1:0] ref_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom());
  endfunction

  // Reference: rank-order over the 3x3 neighbourhood ending at (r, c) of the current frame
  function automatic logic [W-1:0] ref_pixel(input int r, input int c, input logic [1:0] m,
                                             input logic [W-1:0] d);
    logic [W-1:0]  y;
    logic [DW-1:0] v [9];
    logic [DW-1:0] t;
    if (m == 2'b00 || r < 2 || c < 2) return d;
    y = '0;
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < 9; i++) v[i] = img[r-2+i/3][c-2+i%3][k*DW +: DW];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8 - i; j++)
          if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
      case (m)
        2'b01:   y[k*DW +: DW] = v[4];
        2'b10:   y[k*DW +: DW] = v[0];
        default: y[k*DW +: DW] = v[8];
      endcase
    end
    return y;
  endfunction

  task automatic step(input bit r, input bit vs, input bit fl, input logic [W-1:0] d);
    bit rise;
    @(negedge sclk);
    if (cyc > 0) begin
      check("po_flag", 32'(bus.po_flag), 32'(exp_flag[cyc]));
      check("o_vs", 32'(bus.o_vs), 32'(exp_vs[cyc]));
      if (exp_flag[cyc]) check("tx_data", 32'(bus.tx_data), 32'(exp_data[cyc]));
      if (exp_zero[cyc]) check("rst_tx_data", 32'(bus.tx_data), 32'h0);
      if (bus.po_flag === 1'b1) begin
        po_count++;
        if (bus.tx_data === {W{1'b1}}) ff_count++;
        if (capture) cap_q.push_back(bus.tx_data);
      end
    end
    rst         = r;
    bus.i_vs    = vs;
    bus.pi_flag = fl;
    bus.rx_data = d;
    bus.mode    = mode_in;
    if (r) begin
      m_vs_prev = 1'b0;
      m_col     = 0;
      m_row     = 0;
      m_mode    = 2'b01;
      for (int j = 1; j <= 4; j++) begin
        exp_flag[cyc+j] = 1'b0;
        exp_vs[cyc+j]   = 1'b0;
      end
      exp_zero[cyc+1] = 1'b1;
    end else begin
      rise      = vs && !m_vs_prev;
      m_vs_prev = vs;
      exp_vs[cyc+4] = vs;
      if (rise) begin
        m_col  = 0;
        m_row  = 0;
        m_mode = mode_in;
      end
      exp_flag[cyc+4] = fl;
      if (fl) begin
        if (m_row < 16) img[m_row][m_col] = d;
        exp_data[cyc+4] = ref_pixel(m_row, m_col, m_mode, d);
        if (m_col == IMG_W - 1) begin
          m_col = 0;
          if (m_row < 2047) m_row++;
        end else begin
          m_col++;
        end
      end
    end
    cyc++;
    if (cyc >= NCYC - 8) begin
      $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, NCYC - 8);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic gen_random();
    for (int i = 0; i < 64; i++) frame_pix[i] = rnd();
  endtask

  // kind: 0 flat 0x40, 1 impulse at (3,3), 2 ramp on row 0 then random, 3 random
  // gap: idle cycles after each pixel, negative for random 0..2
  task automatic send_frame(input logic [1:0] m, input int kind, input int gap,
                            input int switch_at, input int abort_at);
    logic [W-1:0] d;
    logic [7:0]   cb;
    int           g;
    mode_in  = m;
    ff_count = 0;
    po_count = 0;
    step(1'b0, 1'b1, 1'b0, rnd());
    step(1'b0, 1'b0, 1'b0, rnd());
    for (int i = 0; i < 64; i++) begin
      if (i == switch_at) mode_in = 2'b00;
      if (i == abort_at) begin
        step(1'b1, 1'b0, 1'b0, rnd());
        return;
      end
      cb = 8'(i % IMG_W);
      case (kind)
        0:       d = {CH{8'h40}};
        1:       d = (i == 3 * IMG_W + 3) ? {CH{8'hFF}} : {CH{8'h10}};
        2:       d = (i < IMG_W) ? {CH{cb}} : frame_pix[i];
        default: d = frame_pix[i];
      endcase
      step(1'b0, 1'b0, 1'b1, d);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) step(1'b0, 1'b0, 1'b0, rnd());
    end
    repeat (6) step(1'b0, 1'b0, 1'b0, rnd());
  endtask

  initial begin
    mode_in = 2'b01;
    capture = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, 1'b0, rnd());

    send_frame(2'b01, 0, 0, -1, -1);
    check("flat_count", 32'(po_count), 32'd64);

    send_frame(2'b01, 1, 0, -1, -1);
    check("impulse_median_ff", 32'(ff_count), 32'd0);
    send_frame(2'b11, 1, 0, -1, -1);
    check("impulse_max_ff", 32'(ff_count), 32'd9);

    gen_random();
    send_frame(2'b10, 2, 0, -1, -1);

    gen_random();
    send_frame(2'b01, 3, 0, 20, -1);
    gen_random();
    send_frame(2'b00, 3, 0, -1, -1);

    gen_random();
    cap_q.delete();
    capture = 1'b1;
    send_frame(2'b01, 3, 0, -1, -1);
    ref_q   = cap_q;
    cap_q.delete();
    send_frame(2'b01, 3, 2, -1, -1);
    capture = 1'b0;
    check("gap_count", 32'(cap_q.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++)
      check("gap_vs_cont", 32'(cap_q[i]), 32'(ref_q[i]));

    for (int f = 0; f < 4; f++) begin
      gen_random();
      send_frame(2'($urandom_range(0, 3)), 3, -1, -1, -1);
    end

    gen_random();
    send_frame(2'b01, 3, 0, -1, 13);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, rnd());
    repeat (6) step(1'b0, 1'b0, 1'b0, rnd());
    gen_random();
    send_frame(2'b01, 3, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
